// File: rtl/xover_coeff_ctrl_pkg.sv
// Shared constants and types for the crossover coefficient controller.
// The FSM encoding is kept as plain localparams so older blocks can compare against it directly.
package xover_coeff_ctrl_pkg;

  localparam int c_COEFF_NBITS      = 40;
  localparam int c_NUM_COEFFS       = 20;
  localparam int c_COEFF_ADDR_NBITS = 5;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  // Coefficient index map: four biquads, each laid out as {b0,b1,b2,a1,a2}.
  typedef enum logic [c_COEFF_ADDR_NBITS-1:0] {
    c_IDX_LP0_B0, c_IDX_LP0_B1, c_IDX_LP0_B2, c_IDX_LP0_A1, c_IDX_LP0_A2,
    c_IDX_LP1_B0, c_IDX_LP1_B1, c_IDX_LP1_B2, c_IDX_LP1_A1, c_IDX_LP1_A2,
    c_IDX_HP0_B0, c_IDX_HP0_B1, c_IDX_HP0_B2, c_IDX_HP0_A1, c_IDX_HP0_A2,
    c_IDX_HP1_B0, c_IDX_HP1_B1, c_IDX_HP1_B2, c_IDX_HP1_A1, c_IDX_HP1_A2
  } coeff_idx_e;

  typedef logic [c_COEFF_NBITS-1:0] coeff_t;

endpackage

// File: rtl/xover_coeff_ctrl_if.sv
// Host-side bus of the coefficient controller: shadow write/readback, commit
// handshake, filter status inputs and the flattened active bank.
interface xover_coeff_ctrl_if #(
  parameter int COEFF_NBITS = 40,
  parameter int NUM_COEFFS  = 20,
  parameter int ADDR_NBITS  = 5
);
  logic                              i_wr_en;
  logic [ADDR_NBITS-1:0]             i_wr_addr;
  logic [COEFF_NBITS-1:0]            i_wr_data;
  logic [ADDR_NBITS-1:0]             i_rd_addr;
  logic [COEFF_NBITS-1:0]            o_rd_data;
  logic                              i_commit;
  logic                              i_sample_valid;
  logic                              i_busy_l;
  logic                              i_busy_r;
  logic                              o_pending;
  logic                              o_commit_done;
  logic                              o_wr_err;
  logic [7:0]                        o_swap_count;
  logic [NUM_COEFFS*COEFF_NBITS-1:0] o_coeffs;

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_commit,
           i_sample_valid, i_busy_l, i_busy_r,
    output o_rd_data, o_pending, o_commit_done, o_wr_err, o_swap_count, o_coeffs
  );

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_rd_addr, i_commit,
           i_sample_valid, i_busy_l, i_busy_r,
    input  o_rd_data, o_pending, o_commit_done, o_wr_err, o_swap_count, o_coeffs
  );
endinterface

// File: rtl/xover_coeff_bank.sv
// Coefficient register file: single write port, whole-bank parallel load,
// registered read port and a flat view of every word.
module xover_coeff_bank #(
  parameter int COEFF_NBITS = 40,
  parameter int NUM_COEFFS  = 20,
  parameter int ADDR_NBITS  = 5
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [ADDR_NBITS-1:0]             wr_addr,
  input  logic [COEFF_NBITS-1:0]            wr_data,
  input  logic                              load_en,
  input  logic [NUM_COEFFS*COEFF_NBITS-1:0] load_data,
  input  logic [ADDR_NBITS-1:0]             rd_addr,
  output logic [COEFF_NBITS-1:0]            rd_data,
  output logic [NUM_COEFFS*COEFF_NBITS-1:0] flat
);

  localparam logic [ADDR_NBITS-1:0] LAST_IDX = ADDR_NBITS'(NUM_COEFFS - 1);

  logic [COEFF_NBITS-1:0] mem [NUM_COEFFS];

  // A whole-bank load wins over a single-word write so the copy is never torn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEFFS; i++) mem[i] <= '0;
    end else if (load_en) begin
      for (int i = 0; i < NUM_COEFFS; i++) mem[i] <= load_data[i*COEFF_NBITS +: COEFF_NBITS];
    end else if (wr_en && (wr_addr <= LAST_IDX)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else begin
      rd_data <= (rd_addr <= LAST_IDX) ? mem[rd_addr] : '0;
    end
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_COEFFS; i++) flat[i*COEFF_NBITS +: COEFF_NBITS] = mem[i];
  end

endmodule

// File: rtl/xover_coeff_ctrl.sv
// Double-buffered coefficient controller: the host fills a shadow bank and the
// whole bank is copied to the active bank only while both filters are quiet.
module xover_coeff_ctrl
  import xover_coeff_ctrl_pkg::*;
#(
  parameter int COEFF_NBITS = c_COEFF_NBITS,
  parameter int NUM_COEFFS  = c_NUM_COEFFS,
  parameter int ADDR_NBITS  = c_COEFF_ADDR_NBITS
) (
  input logic               i_mck,
  input logic               i_rstn,
  xover_coeff_ctrl_if.slave bus
);

  localparam logic [ADDR_NBITS-1:0] LAST_IDX = ADDR_NBITS'(NUM_COEFFS - 1);

  logic [0:0]                        state;
  logic                              wr_accept;
  logic                              swap;
  logic                              commit_done;
  logic                              wr_err;
  logic [7:0]                        swap_count;
  logic [NUM_COEFFS*COEFF_NBITS-1:0] shadow_flat;
  logic [NUM_COEFFS*COEFF_NBITS-1:0] active_flat;
  logic [COEFF_NBITS-1:0]            active_rd_unused;

  assign wr_accept = bus.i_wr_en && (bus.i_wr_addr <= LAST_IDX) && (state == ST_IDLE);

  // Sample-start also blocks the swap: stage 0 latches b0 on that same edge.
  assign swap = (state == ST_WAIT) && !bus.i_busy_l && !bus.i_busy_r && !bus.i_sample_valid;

  always_ff @(posedge i_mck or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= ST_IDLE;
      commit_done <= 1'b0;
      wr_err      <= 1'b0;
      swap_count  <= 8'd0;
    end else begin
      commit_done <= swap;
      wr_err      <= bus.i_wr_en && !wr_accept;
      if (swap) swap_count <= swap_count + 8'd1;
      case (state)
        ST_IDLE: if (bus.i_commit) state <= ST_WAIT;
        ST_WAIT: if (swap) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  xover_coeff_bank #(
    .COEFF_NBITS(COEFF_NBITS),
    .NUM_COEFFS (NUM_COEFFS),
    .ADDR_NBITS (ADDR_NBITS)
  ) u_shadow (
    .clk      (i_mck),
    .rst_n    (i_rstn),
    .wr_en    (wr_accept),
    .wr_addr  (bus.i_wr_addr),
    .wr_data  (bus.i_wr_data),
    .load_en  (1'b0),
    .load_data('0),
    .rd_addr  (bus.i_rd_addr),
    .rd_data  (bus.o_rd_data),
    .flat     (shadow_flat)
  );

  xover_coeff_bank #(
    .COEFF_NBITS(COEFF_NBITS),
    .NUM_COEFFS (NUM_COEFFS),
    .ADDR_NBITS (ADDR_NBITS)
  ) u_active (
    .clk      (i_mck),
    .rst_n    (i_rstn),
    .wr_en    (1'b0),
    .wr_addr  ('0),
    .wr_data  ('0),
    .load_en  (swap),
    .load_data(shadow_flat),
    .rd_addr  ('0),
    .rd_data  (active_rd_unused),
    .flat     (active_flat)
  );

  assign bus.o_pending     = (state == ST_WAIT);
  assign bus.o_commit_done = commit_done;
  assign bus.o_wr_err      = wr_err;
  assign bus.o_swap_count  = swap_count;
  assign bus.o_coeffs      = active_flat;

endmodule

// File: tb/tb_xover_coeff_ctrl.sv
// Randomised and directed bench for xover_coeff_ctrl, checked against a
// bank-level model of the shadow/active coefficient behaviour.
module tb_xover_coeff_ctrl;

  localparam int W  = 40;
  localparam int N  = 20;
  localparam int FW = N * W;

  logic clk;
  logic rstn;
  int   assert_count = 0;
  int   fail_count   = 0;

  logic [W-1:0] m_shadow [N];
  logic [W-1:0] m_active [N];
  bit           m_pending;
  logic [7:0]   m_count;
  logic         e_done;
  logic         e_err;
  logic [W-1:0] e_rd;

  xover_coeff_ctrl_if bus ();

  xover_coeff_ctrl dut (
    .i_mck (clk),
    .i_rstn(rstn),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [FW-1:0] actual, input logic [FW-1:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_shadow[k] = '0;
      m_active[k] = '0;
    end
    m_pending = 1'b0;
    m_count   = 8'd0;
    e_done    = 1'b0;
    e_err     = 1'b0;
    e_rd      = '0;
  endtask

  function automatic logic [FW-1:0] expected_flat();
    logic [FW-1:0] f;
    for (int k = 0; k < N; k++) f[k*W +: W] = m_active[k];
    return f;
  endfunction

  task automatic check_all();
    checkOutput("pending", {{(FW-1){1'b0}}, bus.o_pending}, {{(FW-1){1'b0}}, m_pending});
    checkOutput("commit_done", {{(FW-1){1'b0}}, bus.o_commit_done}, {{(FW-1){1'b0}}, e_done});
    checkOutput("wr_err", {{(FW-1){1'b0}}, bus.o_wr_err}, {{(FW-1){1'b0}}, e_err});
    checkOutput("swap_count", {{(FW-8){1'b0}}, bus.o_swap_count}, {{(FW-8){1'b0}}, m_count});
    checkOutput("rd_data", {{(FW-W){1'b0}}, bus.o_rd_data}, {{(FW-W){1'b0}}, e_rd});
    checkOutput("coeffs", bus.o_coeffs, expected_flat());
  endtask

  // One clock of stimulus; the model advances on the edge and everything is compared 1ns later.
  task automatic applyStimulus(input logic wr_en, input logic [4:0] wr_addr, input logic [W-1:0] wr_data,
                               input logic [4:0] rd_addr, input logic commit, input logic sv,
                               input logic bl, input logic br);
    bus.i_wr_en        = wr_en;
    bus.i_wr_addr      = wr_addr;
    bus.i_wr_data      = wr_data;
    bus.i_rd_addr      = rd_addr;
    bus.i_commit       = commit;
    bus.i_sample_valid = sv;
    bus.i_busy_l       = bl;
    bus.i_busy_r       = br;
    @(posedge clk);
    e_rd   = (int'(rd_addr) < N) ? m_shadow[rd_addr] : '0;
    e_err  = wr_en && ((int'(wr_addr) >= N) || m_pending);
    e_done = m_pending && !bl && !br && !sv;
    if (e_done) begin
      for (int k = 0; k < N; k++) m_active[k] = m_shadow[k];
      m_count   = m_count + 8'd1;
      m_pending = 1'b0;
    end else if (!m_pending) begin
      if (wr_en && (int'(wr_addr) < N)) m_shadow[wr_addr] = wr_data;
      if (commit) m_pending = 1'b1;
    end
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic write_word(input logic [4:0] addr, input logic [W-1:0] data);
    applyStimulus(1'b1, addr, data, addr, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic commit_now();
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [63:0] r;
    bus.i_wr_en = 0; bus.i_wr_addr = 0; bus.i_wr_data = 0; bus.i_rd_addr = 0;
    bus.i_commit = 0; bus.i_sample_valid = 0; bus.i_busy_l = 0; bus.i_busy_r = 0;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    model_reset();
    #1 check_all();
    @(posedge clk);
    #2 rstn = 1'b1;

    $display("[TB] shadow writes and readback");
    write_word(5'd0, 40'h10_0000_0000);
    write_word(5'd19, 40'hF0_0000_0000);
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_idx0", {{(FW-W){1'b0}}, bus.o_rd_data}, {{(FW-W){1'b0}}, 40'h10_0000_0000});
    applyStimulus(1'b0, 5'd0, '0, 5'd19, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rd_idx19", {{(FW-W){1'b0}}, bus.o_rd_data}, {{(FW-W){1'b0}}, 40'hF0_0000_0000});
    checkOutput("active_still_zero", bus.o_coeffs, '0);

    $display("[TB] commit with both filters idle");
    commit_now();
    idle(1);
    checkOutput("done_at_commit_plus2", {{(FW-1){1'b0}}, bus.o_commit_done}, {{(FW-1){1'b0}}, 1'b1});
    checkOutput("lp0_b0", {{(FW-W){1'b0}}, bus.o_coeffs[39:0]}, {{(FW-W){1'b0}}, 40'h10_0000_0000});
    checkOutput("hp1_a2", {{(FW-W){1'b0}}, bus.o_coeffs[799:760]}, {{(FW-W){1'b0}}, 40'hF0_0000_0000});
    checkOutput("swap_count_1", {{(FW-8){1'b0}}, bus.o_swap_count}, {{(FW-8){1'b0}}, 8'd1});

    $display("[TB] commit held off by left busy");
    applyStimulus(1'b0, 5'd0, '0, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int c = 0; c < 29; c++)
      applyStimulus(c == 10, 5'd3, 40'h12_3456_789A, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("pending_while_busy", {{(FW-1){1'b0}}, bus.o_pending}, {{(FW-1){1'b0}}, 1'b1});
    applyStimulus(1'b0, 5'd0, '0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("swap_after_busy_drop", {{(FW-1){1'b0}}, bus.o_commit_done}, {{(FW-1){1'b0}}, 1'b1});

    $display("[TB] sample start blocks the swap");
    commit_now();
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] out-of-range writes, write+commit same cycle, repeated commit");
    write_word(5'd20, 40'hAA_AAAA_AAAA);
    write_word(5'd31, 40'h55_5555_5555);
    applyStimulus(1'b0, 5'd0, '0, 5'd20, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 5'd0, '0, 5'd31, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 5'd5, 40'h0C_AFE0_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    checkOutput("lp1_b0_committed", {{(FW-W){1'b0}}, bus.o_coeffs[5*W +: W]}, {{(FW-W){1'b0}}, 40'h0C_AFE0_1234});

    $display("[TB] swap counter wrap");
    for (int c = 0; c < 256; c++) begin
      commit_now();
      idle(1);
    end

    $display("[TB] random traffic");
    for (int c = 0; c < 3000; c++) begin
      r = {$urandom, $urandom};
      applyStimulus($urandom_range(0, 1) == 1, 5'($urandom_range(0, 23)), r[W-1:0],
                    5'($urandom_range(0, 23)), $urandom_range(0, 7) == 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0);
    end

    $display("[TB] reset during WAIT");
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 5'd0, '0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    #1 rstn = 1'b0;
    model_reset();
    #1;
    checkOutput("rst_pending", {{(FW-1){1'b0}}, bus.o_pending}, '0);
    checkOutput("rst_coeffs", bus.o_coeffs, '0);
    check_all();
    @(posedge clk);
    #2 rstn = 1'b1;
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
